// File: rtl/cronometro_lap.sv
// cronometro_lap
// Stopwatch that counts hundredths of a second up to MAX_HOURS hours.
// The time is kept directly as BCD digits, which drive the 7-segment
// decoders with no lag. It also provides an optional lap-capture FIFO.
//
// Parameters
//   CLK_HZ    : input clock frequency, a multiple of 100 (DIV = CLK_HZ/100)
//   MAX_HOURS : hour wrap limit, 1..99 (hours count 0..MAX_HOURS-1)
//   LAP_DEPTH : lap FIFO entries, a power of two >= 2
//
// Ports
//   clk, reset            : rising-edge clock, async active-high reset
//   running               : 1 = count, 0 = pause (state held)
//   clear                 : synchronous zeroing of time, prescaler, FIFO, overflow
//   lap_req, lap_ready    : capture request / consumer accepts head entry
//   hour_tens..milli_sec_units : BCD time digits (milli_sec_* are hundredths)
//   wrap                  : one-cycle pulse after rollover to 0:00:00.00
//   lap_valid, lap_data   : FIFO non-empty / head entry (0 when empty)
//   lap_overflow          : sticky, a capture was dropped on a full FIFO
//
// Build option
//   CRONOMETRO_LAP_EN : when defined, the lap FIFO is built. When it is not
//   defined, lap_req/lap_ready are ignored and the lap outputs are tied to 0.

module cronometro_lap #(
    parameter int CLK_HZ    = 50000000,
    parameter int MAX_HOURS = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        running,
    input  logic        clear,
    input  logic        lap_req,
    input  logic        lap_ready,
    output logic [3:0]  hour_tens,
    output logic [3:0]  hour_units,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_units,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_units,
    output logic [3:0]  milli_sec_tens,
    output logic [3:0]  milli_sec_units,
    output logic        wrap,
    output logic        lap_valid,
    output logic [31:0] lap_data,
    output logic        lap_overflow
);

    localparam int DIV   = CLK_HZ / 100;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [3:0] HOUR_LAST_TENS  = 4'((MAX_HOURS - 1) / 10);
    localparam logic [3:0] HOUR_LAST_UNITS = 4'((MAX_HOURS - 1) % 10);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             rollover;
    logic             c_msu, c_mst, c_su, c_st, c_mu, c_mt;
    logic [3:0]       hour_tens_n, hour_units_n, min_tens_n, min_units_n;
    logic [3:0]       sec_tens_n, sec_units_n, milli_sec_tens_n, milli_sec_units_n;

    assign tick = running && (pre == PRE_LAST);

    // Ripple-carry BCD increment. Each c_* says that digit and everything
    // below it are at their maximum, so the next digit up must advance.
    // With no tick the next value is the current one.
    always_comb begin
        c_msu    = (milli_sec_units == 4'd9);
        c_mst    = c_msu && (milli_sec_tens == 4'd9);
        c_su     = c_mst && (sec_units == 4'd9);
        c_st     = c_su && (sec_tens == 4'd5);
        c_mu     = c_st && (min_units == 4'd9);
        c_mt     = c_mu && (min_tens == 4'd5);
        rollover = c_mt && (hour_tens == HOUR_LAST_TENS) && (hour_units == HOUR_LAST_UNITS);

        hour_tens_n       = hour_tens;
        hour_units_n      = hour_units;
        min_tens_n        = min_tens;
        min_units_n       = min_units;
        sec_tens_n        = sec_tens;
        sec_units_n       = sec_units;
        milli_sec_tens_n  = milli_sec_tens;
        milli_sec_units_n = milli_sec_units;

        if (tick) begin
            milli_sec_units_n = c_msu ? 4'd0 : milli_sec_units + 4'd1;
            if (c_msu) milli_sec_tens_n = c_mst ? 4'd0 : milli_sec_tens + 4'd1;
            if (c_mst) sec_units_n = c_su ? 4'd0 : sec_units + 4'd1;
            if (c_su)  sec_tens_n  = c_st ? 4'd0 : sec_tens + 4'd1;
            if (c_st)  min_units_n = c_mu ? 4'd0 : min_units + 4'd1;
            if (c_mu)  min_tens_n  = c_mt ? 4'd0 : min_tens + 4'd1;
            if (rollover) begin
                hour_tens_n  = 4'd0;
                hour_units_n = 4'd0;
            end else if (c_mt) begin
                if (hour_units == 4'd9) begin
                    hour_units_n = 4'd0;
                    hour_tens_n  = hour_tens + 4'd1;
                end else begin
                    hour_units_n = hour_units + 4'd1;
                end
            end
        end
    end

    // Prescaler, time digits and wrap pulse. The digits are the display, so
    // there is no separate output register. Pausing just freezes pre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre             <= '0;
            hour_tens       <= 4'd0;
            hour_units      <= 4'd0;
            min_tens        <= 4'd0;
            min_units       <= 4'd0;
            sec_tens        <= 4'd0;
            sec_units       <= 4'd0;
            milli_sec_tens  <= 4'd0;
            milli_sec_units <= 4'd0;
            wrap            <= 1'b0;
        end else if (clear) begin
            pre             <= '0;
            hour_tens       <= 4'd0;
            hour_units      <= 4'd0;
            min_tens        <= 4'd0;
            min_units       <= 4'd0;
            sec_tens        <= 4'd0;
            sec_units       <= 4'd0;
            milli_sec_tens  <= 4'd0;
            milli_sec_units <= 4'd0;
            wrap            <= 1'b0;
        end else begin
            if (running) pre <= tick ? '0 : pre + PRE_W'(1);
            hour_tens       <= hour_tens_n;
            hour_units      <= hour_units_n;
            min_tens        <= min_tens_n;
            min_units       <= min_units_n;
            sec_tens        <= sec_tens_n;
            sec_units       <= sec_units_n;
            milli_sec_tens  <= milli_sec_tens_n;
            milli_sec_units <= milli_sec_units_n;
            wrap            <= tick && rollover;
        end
    end

`ifdef CRONOMETRO_LAP_EN
    localparam int AW = $clog2(LAP_DEPTH);

    logic [31:0] lap_mem [LAP_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] snapshot;
    logic        fifo_empty, fifo_full, do_read, do_write;

    // A capture stores the digits as displayed this cycle, before any tick
    // on the same edge lands.
    assign snapshot   = {hour_tens, hour_units, min_tens, min_units,
                         sec_tens, sec_units, milli_sec_tens, milli_sec_units};
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_read    = !fifo_empty && lap_ready;
    // A read on the same edge frees a slot, so a full FIFO still accepts.
    assign do_write   = lap_req && (!fifo_full || do_read);

    // FIFO pointers and the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            if (lap_req && !do_write) lap_overflow <= 1'b1;
        end
    end

    // Storage has no reset. Entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (!clear && do_write) lap_mem[wr_ptr[AW-1:0]] <= snapshot;
    end

    assign lap_valid = !fifo_empty;
    assign lap_data  = fifo_empty ? 32'd0 : lap_mem[rd_ptr[AW-1:0]];
`else
    logic lap_unused;

    assign lap_unused   = lap_req | lap_ready;
    assign lap_valid    = 1'b0;
    assign lap_data     = 32'd0;
    assign lap_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cronometro_lap.sv
// tb_cronometro_lap
// Testbench for cronometro_lap with DIV=4, MAX_HOURS=2 and LAP_DEPTH=4.
// The reference model keeps the time as a single count of hundredths and
// the laps in a queue. It derives the BCD digits arithmetically.

module tb_cronometro_lap;

    localparam int CLK_HZ    = 400;
    localparam int MAX_HOURS = 2;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / 100;
    localparam int DAY       = MAX_HOURS * 360000;
`ifdef CRONOMETRO_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        running = 1'b0;
    logic        clear = 1'b0;
    logic        lapReq = 1'b0;
    logic        lapReady = 1'b0;
    logic [3:0]  hourTens, hourUnits, minTens, minUnits;
    logic [3:0]  secTens, secUnits, msTens, msUnits;
    logic        wrap, lapValid, lapOverflow;
    logic [31:0] lapData;
    logic [31:0] digits;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          modelTime;
    int          modelPhase;
    bit          modelWrap;
    bit          modelOverflow;
    logic [31:0] modelQ[$];

    typedef struct {
        bit          run;
        bit          clr;
        bit          req;
        bit          rdy;
        logic [3:0]  expMsUnits;
        bit          expValid;
        logic [31:0] expData;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    assign digits = {hourTens, hourUnits, minTens, minUnits, secTens, secUnits, msTens, msUnits};

    cronometro_lap #(
        .CLK_HZ(CLK_HZ),
        .MAX_HOURS(MAX_HOURS),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .running(running),
        .clear(clear),
        .lap_req(lapReq),
        .lap_ready(lapReady),
        .hour_tens(hourTens),
        .hour_units(hourUnits),
        .min_tens(minTens),
        .min_units(minUnits),
        .sec_tens(secTens),
        .sec_units(secUnits),
        .milli_sec_tens(msTens),
        .milli_sec_units(msUnits),
        .wrap(wrap),
        .lap_valid(lapValid),
        .lap_data(lapData),
        .lap_overflow(lapOverflow)
    );

    // Hundredths count -> packed BCD digits, MSB = hour tens
    function automatic logic [31:0] packTime(input int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        modelTime     = 0;
        modelPhase    = 0;
        modelWrap     = 0;
        modelOverflow = 0;
        modelQ.delete();
    endtask

    // One rising edge of the model, using the inputs the DUT sampled
    task automatic modelStep();
        logic [31:0] snap;
        bit          canRead;
        if (clear) begin
            modelReset();
            return;
        end
        snap      = packTime(modelTime);
        modelWrap = 0;
        if (LAP_EN) begin
            canRead = (modelQ.size() > 0) && lapReady;
            if (lapReq && (modelQ.size() == LAP_DEPTH) && !canRead) modelOverflow = 1;
            if (canRead) void'(modelQ.pop_front());
            if (lapReq && (modelQ.size() < LAP_DEPTH)) modelQ.push_back(snap);
        end
        if (running) begin
            modelPhase++;
            if (modelPhase == DIV) begin
                modelPhase = 0;
                modelTime++;
                if (modelTime == DAY) begin
                    modelTime = 0;
                    modelWrap = 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " digits"}, digits, packTime(modelTime));
        checkValue({tag, " wrap"}, 32'(wrap), 32'(modelWrap));
        checkValue({tag, " lap_valid"}, 32'(lapValid), 32'(modelQ.size() > 0));
        checkValue({tag, " lap_data"}, lapData, (modelQ.size() > 0) ? modelQ[0] : 32'd0);
        checkValue({tag, " lap_overflow"}, 32'(lapOverflow), 32'(modelOverflow));
    endtask

    // Drive one cycle of inputs, step the model on the edge, compare 1ns later
    task automatic applyStimulus(input bit run, input bit clr, input bit req, input bit rdy, input string tag);
        running  = run;
        clear    = clr;
        lapReq   = req;
        lapReady = rdy;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    // Assert reset mid-cycle and check the outputs drop before the next edge
    task automatic doReset();
        #2;
        reset    = 1'b1;
        running  = 1'b0;
        clear    = 1'b0;
        lapReq   = 1'b0;
        lapReady = 1'b0;
        modelReset();
        #1;
        checkOutput("async reset");
        checkValue("async reset digits zero", digits, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 4'd0, 0, 32'd0};
        vecs[1]  = '{1, 0, 0, 0, 4'd0, 0, 32'd0};
        vecs[2]  = '{1, 0, 0, 0, 4'd0, 0, 32'd0};
        vecs[3]  = '{1, 0, 0, 0, 4'd1, 0, 32'd0};
        vecs[4]  = '{0, 0, 0, 0, 4'd1, 0, 32'd0};
        vecs[5]  = '{0, 0, 1, 0, 4'd1, 1, 32'd1};
        vecs[6]  = '{1, 0, 0, 0, 4'd1, 1, 32'd1};
        vecs[7]  = '{1, 0, 0, 0, 4'd1, 1, 32'd1};
        vecs[8]  = '{1, 0, 0, 0, 4'd1, 1, 32'd1};
        vecs[9]  = '{1, 0, 0, 0, 4'd2, 1, 32'd1};
        vecs[10] = '{1, 0, 0, 1, 4'd2, 0, 32'd0};
        vecs[11] = '{1, 1, 0, 0, 4'd0, 0, 32'd0};
        vecs[12] = '{1, 0, 0, 0, 4'd0, 0, 32'd0};
        vecs[13] = '{1, 0, 0, 0, 4'd0, 0, 32'd0};
        vecs[14] = '{1, 0, 0, 0, 4'd0, 0, 32'd0};
        vecs[15] = '{1, 0, 0, 0, 4'd1, 0, 32'd0};

        doReset();

        // Directed vector table: first tick timing, pause, lap, read, clear
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].run, vecs[i].clr, vecs[i].req, vecs[i].rdy, "vec");
            checkValue("vec ms_units", 32'(msUnits), 32'(vecs[i].expMsUnits));
            checkValue("vec lap_valid", 32'(lapValid), 32'(vecs[i].expValid && LAP_EN));
            checkValue("vec lap_data", lapData, LAP_EN ? vecs[i].expData : 32'd0);
        end

        // Count: 40 running cycles give 0.10 s
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 0, "count");
        checkValue("count 40 cycles", digits, 32'h0000_0010);

        // Pause: 10 run + 7 paused + 6 run = 16 running cycles = 4 ticks
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, "pause run");
        for (int i = 0; i < 7; i++)  applyStimulus(0, 0, 0, 0, "pause hold");
        for (int i = 0; i < 6; i++)  applyStimulus(1, 0, 0, 0, "pause resume");
        checkValue("pause ticks", digits, 32'h0000_0004);

        // Lap on a tick edge captures .05 while the display moves to .06
        doReset();
        for (int i = 0; i < 23; i++) applyStimulus(1, 0, 0, 0, "collision run");
        applyStimulus(1, 0, 1, 0, "collision lap");
        checkValue("collision display", digits, 32'h0000_0006);
        checkValue("collision lap_data", lapData, LAP_EN ? 32'h0000_0005 : 32'd0);

        // FIFO full: five captures at .00 .. .04, the fifth is dropped
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, 0, "full lap");
            for (int j = 0; j < 3; j++) applyStimulus(1, 0, 0, 0, "full run");
        end
        checkValue("full lap_valid", 32'(lapValid), 32'(LAP_EN));
        checkValue("full lap_overflow", 32'(lapOverflow), 32'(LAP_EN));
        for (int i = 0; i < 4; i++) begin
            checkValue("drain order", lapData, LAP_EN ? 32'(i) : 32'd0);
            applyStimulus(0, 0, 0, 1, "drain");
        end
        checkValue("drained lap_valid", 32'(lapValid), 32'd0);
        checkValue("overflow sticky", 32'(lapOverflow), 32'(LAP_EN));

        // Full FIFO with a simultaneous read accepts the new capture
        applyStimulus(0, 1, 0, 0, "refill clear");
        checkValue("refill clear overflow", 32'(lapOverflow), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, "refill lap");
        applyStimulus(1, 0, 1, 1, "full read+write");
        checkValue("full read+write overflow", 32'(lapOverflow), 32'd0);
        checkValue("full read+write valid", 32'(lapValid), 32'(LAP_EN));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, "refill drain");
        checkValue("refill drained valid", 32'(lapValid), 32'd0);

        // Clear mid-run with pending laps and an overflow
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0, "pre-clear");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "pre-clear run");
        applyStimulus(1, 1, 0, 0, "clear");
        checkValue("clear digits", digits, 32'd0);
        checkValue("clear lap_valid", 32'(lapValid), 32'd0);
        checkValue("clear lap_overflow", 32'(lapOverflow), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "post-clear");
        checkValue("post-clear no early tick", digits, 32'd0);
        applyStimulus(1, 0, 0, 0, "post-clear tick");
        checkValue("post-clear tick at DIV", digits, 32'h0000_0001);

        // Async reset in the middle of a count with laps pending
        for (int i = 0; i < 13; i++) applyStimulus(1, 0, i == 5, 0, "pre-reset");
        doReset();
        checkValue("reset lap_valid", 32'(lapValid), 32'd0);

        // Wrap: preload 1:59:59.99 while paused, then let one tick roll over
        force dut.hour_tens       = 4'd0;
        force dut.hour_units      = 4'd1;
        force dut.min_tens        = 4'd5;
        force dut.min_units       = 4'd9;
        force dut.sec_tens        = 4'd5;
        force dut.sec_units       = 4'd9;
        force dut.milli_sec_tens  = 4'd9;
        force dut.milli_sec_units = 4'd9;
        running = 1'b0;
        @(posedge clk);
        #1;
        release dut.hour_tens;
        release dut.hour_units;
        release dut.min_tens;
        release dut.min_units;
        release dut.sec_tens;
        release dut.sec_units;
        release dut.milli_sec_tens;
        release dut.milli_sec_units;
        modelTime = DAY - 1;
        #1;
        checkValue("preload digits", digits, 32'h0159_5999);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "pre-wrap");
        applyStimulus(1, 0, 0, 0, "wrap edge");
        checkValue("wrap digits", digits, 32'd0);
        checkValue("wrap pulse", 32'(wrap), 32'd1);
        applyStimulus(1, 0, 0, 0, "after wrap");
        checkValue("wrap one cycle", 32'(wrap), 32'd0);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
